// File: rtl/tune_pkg.sv
// Shared types and timing constants for the tune sequencer.
// Note durations are expressed in 50 MHz clocks before FAST_SIM scaling.
package tune_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_PLAY  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   typedef struct packed {
      logic        last;
      logic [1:0]  dur;
      logic [15:0] half_per;
   } note_entry_t;

   localparam logic [31:0] DUR_CYC_0 = 32'h0040_0000;  // 2^22
   localparam logic [31:0] DUR_CYC_1 = 32'h0080_0000;  // 2^23
   localparam logic [31:0] DUR_CYC_2 = 32'h00C0_0000;  // 3*2^22
   localparam logic [31:0] DUR_CYC_3 = 32'h0100_0000;  // 2^24

   localparam logic [31:0] FAST_INC = 32'd16;

   localparam note_entry_t NOTE_RESET = '{last: 1'b1, dur: 2'd0, half_per: 16'd0};

   function automatic logic [31:0] dur_cycles(input logic [1:0] code);
      case (code)
         2'd0:    return DUR_CYC_0;
         2'd1:    return DUR_CYC_1;
         2'd2:    return DUR_CYC_2;
         default: return DUR_CYC_3;
      endcase
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles its output every half_per enabled clocks.
// The wave restarts low whenever the enable drops, so each note begins at 0.
module tone_gen
   import tune_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] half_per,
   output logic        tone,
   output logic        active
);

   logic [15:0] cnt;

   assign active = en && (half_per != 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (!active) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (cnt >= 16'(half_per - 16'd1)) begin
         cnt  <= '0;
         tone <= ~tone;
      end else begin
         cnt  <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/tune_seq.sv
// Tune sequencer: steps through a writable note table, playing each entry as a
// square wave for its duration followed by a silent gap, with loop and abort.
module tune_seq
   import tune_pkg::*;
#(
   parameter bit FAST_SIM  = 1'b0,
   parameter int NUM_NOTES = 8,
   parameter int GAP_CYC   = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic        stop,
   input  logic        loop,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [18:0] wr_data,
   output logic        piezo,
   output logic        piezo_n,
   output logic        busy,
   output logic        done,
   output logic [3:0]  note_idx
);

   localparam int          IDX_W    = $clog2(NUM_NOTES);
   localparam logic [31:0] INC      = FAST_SIM ? FAST_INC : 32'd1;
   localparam logic [31:0] GAP_LIM  = 32'(GAP_CYC);
   localparam logic [3:0]  LAST_IDX = 4'(NUM_NOTES - 1);

   state_t      state;
   note_entry_t tbl [NUM_NOTES];
   note_entry_t cur;
   logic [31:0] tmr;
   logic [32:0] tmr_sum;
   logic [32:0] limit;
   logic        tmr_end;
   logic        entry_last;
   logic        wr_ok;
   logic        tone;
   logic        tone_on;

   // The timer holds elapsed time in unscaled clocks, so the limit is compared
   // against the value it would reach after this clock's increment.
   always_comb begin
      limit   = (state == ST_GAP) ? {1'b0, GAP_LIM} : {1'b0, dur_cycles(cur.dur)};
      tmr_sum = {1'b0, tmr} + {1'b0, INC};
      tmr_end = (tmr_sum >= limit);
   end

   assign entry_last = cur.last || (note_idx == LAST_IDX);
   assign wr_ok      = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < 5'(NUM_NOTES));
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NOTES; i++) tbl[i] <= NOTE_RESET;
      end else if (wr_ok) begin
         tbl[wr_addr[IDX_W-1:0]] <= note_entry_t'(wr_data);
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_FETCH) cur <= tbl[note_idx[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         note_idx <= '0;
         tmr      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state <= ST_IDLE;
            tmr   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (go) begin
                     state    <= ST_FETCH;
                     note_idx <= '0;
                     tmr      <= '0;
                  end
               end
               ST_FETCH: begin
                  state <= ST_PLAY;
                  tmr   <= '0;
               end
               ST_PLAY: begin
                  if (tmr_end) begin
                     state <= ST_GAP;
                     tmr   <= '0;
                  end else begin
                     tmr <= tmr_sum[31:0];
                  end
               end
               ST_GAP: begin
                  if (!tmr_end) begin
                     tmr <= tmr_sum[31:0];
                  end else begin
                     tmr <= '0;
                     if (!entry_last) begin
                        note_idx <= note_idx + 4'd1;
                        state    <= ST_FETCH;
                     end else if (loop) begin
                        note_idx <= '0;
                        state    <= ST_FETCH;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   tone_gen u_tone (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == ST_PLAY),
      .half_per (cur.half_per),
      .tone     (tone),
      .active   (tone_on)
   );

   assign piezo   = tone_on && tone;
   assign piezo_n = tone_on && !tone;

endmodule

// File: tb/tb_tune_seq.sv
// Scoreboard bench for tune_seq: stimulus pushes expected per-note segments and
// end-of-tune records; a negedge monitor rebuilds them from the DUT pins.
module tb_tune_seq;

   localparam int N     = 8;
   localparam int GAP   = 65536;
   localparam int INC   = 16;
   localparam int GAP_C = GAP / INC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [18:0] wr_data = '0;
   logic        piezo, piezo_n, busy, done;
   logic [3:0]  note_idx;

   tune_seq #(.FAST_SIM(1'b1), .NUM_NOTES(N), .GAP_CYC(GAP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (go),
      .stop     (stop),
      .loop     (loop),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .piezo    (piezo),
      .piezo_n  (piezo_n),
      .busy     (busy),
      .done     (done),
      .note_idx (note_idx)
   );

   always #10 clk = ~clk;

   // kind 0: one note segment (FETCH+PLAY+GAP); kind 1: end of tune (idx=done, len=busy clocks)
   typedef struct {
      int kind;
      int idx;
      int len;
      int active;
      int high;
      int first;
      int rise;
   } txn_t;

   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_last [N];
   int   m_dur  [N];
   int   m_hp   [N];
   bit   tune_active = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int play_clks(input int dur);
      case (dur)
         0:       return (1 << 22) / INC;
         1:       return (1 << 23) / INC;
         2:       return (3 << 22) / INC;
         default: return (1 << 24) / INC;
      endcase
   endfunction

   // clocks with piezo high among the first p clocks of a wave that starts low
   function automatic int high_clks(input int p, input int h);
      int rem;
      if (h == 0) return 0;
      rem = p % (2 * h);
      return (p / (2 * h)) * h + ((rem > h) ? rem - h : 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_last[i] = 1; m_dur[i] = 0; m_hp[i] = 0;
      end
   endtask

   task automatic model_write(input int a, input int last, input int dur, input int hp);
      if (a < N && !tune_active) begin
         m_last[a] = last; m_dur[a] = dur; m_hp[a] = hp;
      end
   endtask

   task automatic push_seg(input int idx, input int p, input int len);
      txn_t t;
      t.kind   = 0;
      t.idx    = idx;
      t.len    = len;
      t.active = (m_hp[idx] != 0) ? p : 0;
      t.high   = high_clks(p, m_hp[idx]);
      t.first  = (m_hp[idx] != 0 && p > 0) ? 1 : -1;
      t.rise   = (m_hp[idx] != 0 && p > m_hp[idx]) ? 1 + m_hp[idx] : -1;
      exp_q.push_back(t);
   endtask

   task automatic push_end(input int d, input int busy_len);
      txn_t t;
      t = '{kind: 1, idx: d, len: busy_len, active: 0, high: 0, first: 0, rise: 0};
      exp_q.push_back(t);
   endtask

   task automatic expect_tune(input int passes);
      int idx = 0;
      int pass = 0;
      int total = 0;
      int p;
      forever begin
         p = play_clks(m_dur[idx]);
         push_seg(idx, p, 1 + p + GAP_C);
         total += 1 + p + GAP_C;
         if (m_last[idx] != 0 || idx == N - 1) begin
            pass++;
            if (pass == passes) begin
               push_end(1, total);
               break;
            end
            idx = 0;
         end else begin
            idx++;
         end
      end
   endtask

   // tune aborted in PLAY of entry 0 after busy_len busy clocks
   task automatic expect_abort(input int busy_len);
      push_seg(0, busy_len - 1, busy_len);
      push_end(0, busy_len);
   endtask

   // ---------------- monitor ----------------
   bit         prev_busy = 1'b0;
   logic [3:0] prev_idx = '0;
   int s_idx, s_len, s_act, s_high, s_first, s_rise, s_bad, b_len;
   bit s_prevp;

   task automatic close_seg();
      txn_t e;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL seg_unexpected: idx %0d len %0d, expected no segment", s_idx, s_len);
      end else begin
         e = exp_q.pop_front();
         check("seg_kind", 0, e.kind);
         check("seg_idx", s_idx, e.idx);
         check("seg_len", s_len, e.len);
         check("seg_active", s_act, e.active);
         check("seg_high", s_high, e.high);
         check("seg_first", s_first, e.first);
         check("seg_rise", s_rise, e.rise);
         check("seg_antiphase", s_bad, 0);
      end
   endtask

   task automatic close_end(input int d);
      txn_t e;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL end_unexpected: busy %0d done %0d, expected no tune end", b_len, d);
      end else begin
         e = exp_q.pop_front();
         check("end_kind", 1, e.kind);
         check("end_done", d, e.idx);
         check("end_busy_len", b_len, e.len);
      end
   endtask

   always @(negedge clk) begin
      if (busy && (!prev_busy || note_idx != prev_idx)) begin
         if (prev_busy) close_seg();
         s_idx = int'(note_idx); s_len = 0; s_act = 0; s_high = 0;
         s_first = -1; s_rise = -1; s_bad = 0; s_prevp = 1'b0;
      end
      if (busy && !prev_busy) b_len = 0;
      if (busy) begin
         if ((piezo || piezo_n) && s_first < 0) s_first = s_len;
         if (piezo && !s_prevp && s_rise < 0) s_rise = s_len;
         if (piezo || piezo_n) s_act++;
         if (piezo) s_high++;
         if (piezo && piezo_n) s_bad++;
         s_prevp = piezo;
         s_len++;
         b_len++;
      end else begin
         check("idle_piezo", int'(piezo | piezo_n), 0);
         if (prev_busy) begin
            close_seg();
            close_end(int'(done));
         end
      end
      if (done && !(prev_busy && !busy)) check("done_spurious", int'(done), 0);
      prev_busy = busy;
      prev_idx  = note_idx;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_note(input int a, input int last, input int dur, input int hp);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = {1'(last), 2'(dur), 16'(hp)};
      model_write(a, last, dur, hp);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic press_go();
      go = 1'b1;
      tune_active = 1'b1;
      tick(1);
      go = 1'b0;
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      check("stop_busy", int'(busy), 0);
      check("stop_piezo", int'(piezo | piezo_n), 0);
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         tick(1);
         c++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d txns pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      tick(2);
      tune_active = 1'b0;
   endtask

   initial begin
      int h1, h2, h3, h4, m, seg0;
      model_reset();
      #5;
      check("rst_busy", int'(busy), 0);
      check("rst_piezo", int'(piezo), 0);
      check("rst_piezo_n", int'(piezo_n), 0);
      check("rst_done", int'(done), 0);
      check("rst_note_idx", int'(note_idx), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // single note
      write_note(0, 1, 1, 12500);
      expect_tune(1);
      press_go();
      check("busy_after_go", int'(busy), 1);
      drain(600000);

      // sequence with a rest
      write_note(0, 0, 0, 15944);
      write_note(1, 0, 0, 0);
      write_note(2, 1, 3, 10562);
      expect_tune(1);
      press_go();
      drain(1700000);

      // loop: two passes, loop dropped during the second
      write_note(0, 0, 0, $urandom_range(1000, 20000));
      write_note(1, 1, 0, $urandom_range(1000, 20000));
      loop = 1'b1;
      expect_tune(2);
      press_go();
      tick(2 * (1 + play_clks(0) + GAP_C) + $urandom_range(100, 5000));
      loop = 1'b0;
      drain(600000);

      // stop mid-PLAY, then go+stop together in IDLE
      h1 = $urandom_range(20, 120);
      m  = $urandom_range(400, 1500);
      write_note(0, 1, 0, h1);
      expect_abort(m);
      press_go();
      tick(m - 1);
      stop_pulse();
      drain(100);
      go = 1'b1; stop = 1'b1;
      tick(1);
      go = 1'b0; stop = 1'b0;
      tick(3);
      check("go_stop_idle", int'(busy), 0);

      // write guards: write while busy, write out of range, then write+go
      h1 = $urandom_range(20, 60);
      h2 = h1 + $urandom_range(10, 40);
      h3 = h2 + $urandom_range(10, 40);
      h4 = h3 + $urandom_range(10, 40);
      m  = $urandom_range(400, 1500);
      write_note(0, 1, 0, h1);
      expect_abort(m);
      press_go();
      write_note(0, 1, 0, h2);
      tick(m - 2);
      stop_pulse();
      drain(100);
      write_note(N, 1, 0, h3);
      expect_abort(m);
      press_go();
      tick(m - 1);
      stop_pulse();
      drain(100);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = {1'b1, 2'd0, 16'(h4)};
      model_write(0, 1, 0, h4);
      expect_abort(m);
      go = 1'b1;
      tune_active = 1'b1;
      tick(1);
      wr_en = 1'b0; go = 1'b0;
      tick(m - 1);
      stop_pulse();
      drain(100);

      // reset during entry 1
      write_note(0, 0, 0, $urandom_range(1000, 20000));
      write_note(1, 1, 2, $urandom_range(20, 200));
      seg0 = 1 + play_clks(0) + GAP_C;
      m    = seg0 + $urandom_range(300, 1000);
      push_seg(0, play_clks(0), seg0);
      push_seg(1, m - 2 - seg0, m - 1 - seg0);
      push_end(0, m - 1);
      press_go();
      tick(m - 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_piezo", int'(piezo | piezo_n), 0);
      check("midrst_note_idx", int'(note_idx), 0);
      check("midrst_done", int'(done), 0);
      tick(1);
      rst_n = 1'b1;
      drain(100);
      for (int i = 0; i < N; i++)
         check($sformatf("rst_table_%0d", i), int'(dut.tbl[i]),
               (m_last[i] << 18) | (m_dur[i] << 16) | m_hp[i]);

      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tune_seq.md
TUNE_SEQ -- requirements
Module: tune_seq

Interface
REQ-001 Parameter FAST_SIM, default 0: when 1, duration and gap timers advance by 16 per clock instead of 1.
REQ-002 Parameter NUM_NOTES, default 8, range 2..16: number of note-table entries.
REQ-003 Parameter GAP_CYC, default 65536: silent clocks between consecutive notes, before FAST_SIM scaling.
REQ-004 Port clk, input, 1: 50MHz system clock; reset is asynchronous and active-low.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port go, input, 1: start playback from entry 0.
REQ-007 Port stop, input, 1: abort playback.
REQ-008 Port loop, input, 1: level; repeat the tune at its end.
REQ-009 Port wr_en, input, 1: note-table write strobe.
REQ-010 Port wr_addr, input, 4: table index.
REQ-011 Port wr_data, input, 19: {last[18], dur[17:16], half_per[15:0]}.
REQ-012 Port piezo, output, 1: tone drive.
REQ-013 Port piezo_n, output, 1: complementary tone drive.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-clock pulse when a tune ends normally.
REQ-016 Port note_idx, output, 4: index of the current entry.

Function
REQ-017 FSM states: IDLE, FETCH, PLAY, GAP.
REQ-018 IDLE: go=1 and stop=0 -> FETCH, note_idx<=0.
REQ-019 FETCH: latch table[note_idx], go to PLAY next clock.
REQ-020 PLAY lasts exactly D/INC clocks, then GAP. INC = 16 if FAST_SIM else 1. D by dur: 0 -> 2^22, 1 -> 2^23, 2 -> 3*2^22, 3 -> 2^24.
REQ-021 GAP: piezo=piezo_n=0 for GAP_CYC/INC clocks.
REQ-022 GAP end with last=0: note_idx+1, -> FETCH.
REQ-023 GAP end with last=1 and loop=1: note_idx<=0, -> FETCH, no done.
REQ-024 GAP end with last=1 and loop=0: done pulse, -> IDLE.
REQ-025 GAP end at note_idx=NUM_NOTES-1 with last=0: treated as last=1.
REQ-026 Tone in PLAY: half-period counter counts 0..half_per-1, then wraps. piezo toggles on each wrap (50% duty). piezo starts at 0 each note, and piezo_n=~piezo.
REQ-027 Rest: a PLAY with half_per=0 drives piezo=piezo_n=0 for the full duration.
REQ-028 Outside PLAY, piezo=piezo_n=0.
REQ-029 stop=1 in any non-IDLE state -> IDLE next clock, no done, outputs low. stop beats go when both are high in the same cycle.
REQ-030 go while busy is ignored.
REQ-031 Writes are accepted only in IDLE and ignored while busy.
REQ-032 A write and go in the same IDLE cycle: the write lands, and FETCH sees the new data.
REQ-033 wr_addr>=NUM_NOTES: write discarded.
REQ-034 Duration and gap timers clear on every state entry and never wrap; compare with >=.

Reset
REQ-035 rst_n=0 forces, asynchronously, state=IDLE, note_idx=0, timers=0, piezo=piezo_n=0, busy=0, done=0.
REQ-036 rst_n=0 sets every table entry to {last=1, dur=0, half_per=0}.
REQ-037 Reset mid-tune aborts with no done pulse.

Structure
REQ-038 Package tune_pkg holds: state_t enum, note_entry_t packed struct, dur-code-to-cycle constants, FAST_SIM increment constant.
REQ-039 One sub-module, tone_gen (half-period counter + toggle flop, enable and half_per inputs), instantiated once.
REQ-040 The note table is a flop array inside tune_seq; no RAM macro.

Verification (FAST_SIM=1, GAP_CYC=65536)
REQ-041 Bench scenario, single note: table[0]={1,1,12500}, go pulse.
- busy next clock; PLAY 524288 clocks; piezo period 25000 clocks at 50% duty, piezo_n inverse.
- GAP 4096 clocks; done one clock; then IDLE.
REQ-042 Bench scenario, sequence with rest: entries {0,0,15944}, {0,0,0}, {1,3,10562}.
- note_idx steps 0,1,2; entry 1 drives piezo=piezo_n=0 for 262144 clocks.
- Total busy time = 262144+262144+1048576+3*(4096+1) clocks.
REQ-043 Bench scenario, loop: two-entry tune with loop=1; note_idx 0,1,0,1, no done. Drop loop during the second pass; done at the end of entry 1.
REQ-044 Bench scenario, stop: stop in the middle of PLAY -> IDLE next clock, piezo=0, no done.
- Then go together with stop in IDLE -> stays IDLE.
REQ-045 Bench scenario, write guards: write while busy, and write to wr_addr=NUM_NOTES; table unchanged in both cases.
- Then write+go in the same cycle; first note uses the new half_per.
REQ-046 Bench scenario, reset mid-tune: assert rst_n=0 mid-tune -> outputs low immediately; table reads back all {1,0,0}.
